// File: rtl/sand_pkg.sv
// Shared definitions for the brush command queue: bus action codes and the
// command entry layout. Optional readback is enabled with BRUSH_CMD_READBACK_EN.
package sand_pkg;

    typedef enum logic [2:0] {
        ACT_X       = 3'd0,
        ACT_Y       = 3'd1,
        ACT_RADIUS  = 3'd2,
        ACT_TYPE    = 3'd3,
        ACT_COMMIT  = 3'd4,
        ACT_CLR_ERR = 3'd5,
        ACT_FLUSH   = 3'd6
    } action_t;

    localparam int COORD_W_DEF = 8;
    localparam int TYPE_W_DEF  = 3;

    // Default-width layout; modules re-declare the same field order with their own widths.
    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] radius;
        logic [TYPE_W_DEF-1:0]  kind;
    } brush_cmd_t;

    function automatic int brush_cmd_width(int coord_w, int type_w);
        return 3 * coord_w + type_w;
    endfunction

endpackage

// File: rtl/brush_cmd_queue_if.sv
// Register bus and command-stream signals of brush_cmd_queue.
// BRUSH_CMD_READBACK_EN adds read_enable/readdata.
interface brush_cmd_queue_if #(
    parameter int COORD_W = 8,
    parameter int TYPE_W  = 3,
    parameter int DEPTH   = 4
);
    logic                       chipselect;
    logic                       write_enable;
    logic [2:0]                 action;
    logic [COORD_W-1:0]         payload;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [COORD_W-1:0]         cmd_x;
    logic [COORD_W-1:0]         cmd_y;
    logic [COORD_W-1:0]         cmd_radius;
    logic [TYPE_W-1:0]          cmd_type;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       error;
`ifdef BRUSH_CMD_READBACK_EN
    logic                       read_enable;
    logic [15:0]                readdata;
`endif

    modport slave (
`ifdef BRUSH_CMD_READBACK_EN
        input  read_enable,
        output readdata,
`endif
        input  chipselect, write_enable, action, payload, cmd_ready,
        output cmd_valid, cmd_x, cmd_y, cmd_radius, cmd_type, count, error
    );

    modport master (
`ifdef BRUSH_CMD_READBACK_EN
        output read_enable,
        input  readdata,
`endif
        output chipselect, write_enable, action, payload, cmd_ready,
        input  cmd_valid, cmd_x, cmd_y, cmd_radius, cmd_type, count, error
    );

endinterface

// File: rtl/sand_sync_fifo.sv
// Synchronous FIFO with registered head output, same-cycle push/pop when full,
// and a single-cycle flush that overrides pop.
module sand_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr, head_idx;
    logic             push_ok, pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && !empty && !flush;
    assign push_ok  = push && !flush && (!full || pop_ok);
    assign head_idx = pop_ok ? PW'(rptr + PW'(1)) : rptr;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= PW'(wptr + PW'(1));
            rptr <= head_idx;
            if (push_ok && !pop_ok)
                count <= CW'(count + CW'(1));
            else if (pop_ok && !push_ok)
                count <= CW'(count - CW'(1));
            // The slot becoming head is the one being written only when the queue drains to it.
            rdata <= (push_ok && (wptr == head_idx)) ? wdata : mem[head_idx];
        end
    end

endmodule

// File: rtl/brush_cmd_queue.sv
// Staged brush registers written over a simple bus, committed into a command FIFO.
// BRUSH_CMD_READBACK_EN adds a registered register readback port.
module brush_cmd_queue
    import sand_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int TYPE_W    = 3,
    parameter int NUM_TYPES = 4,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    brush_cmd_queue_if.slave  bus
);
    localparam int W = brush_cmd_width(COORD_W, TYPE_W);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] radius;
        logic [TYPE_W-1:0]  kind;
    } entry_t;

    entry_t         stg;
    logic [W-1:0]   head_bits;
    entry_t         head;
    action_t        act;
    logic           wr, pop, push, flush, full, empty, type_bad, error_q;

    assign act      = action_t'(bus.action);
    assign wr       = bus.chipselect && bus.write_enable;
    assign pop      = !empty && bus.cmd_ready;
    assign type_bad = (32'(stg.kind) >= 32'(NUM_TYPES));
    assign push     = wr && (act == ACT_COMMIT) && !type_bad;
    assign flush    = wr && (act == ACT_FLUSH);
    assign head     = entry_t'(head_bits);

    sand_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (stg),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (bus.count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg     <= '0;
            error_q <= 1'b0;
        end else if (wr) begin
            case (act)
                ACT_X:       stg.x      <= bus.payload;
                ACT_Y:       stg.y      <= bus.payload;
                ACT_RADIUS:  stg.radius <= bus.payload;
                ACT_TYPE:    stg.kind   <= bus.payload[TYPE_W-1:0];
                ACT_COMMIT:  if (type_bad || (full && !pop)) error_q <= 1'b1;
                ACT_CLR_ERR: error_q <= 1'b0;
                ACT_FLUSH:   ;
                default:     error_q <= 1'b1;
            endcase
        end
    end

    assign bus.cmd_valid  = !empty;
    assign bus.cmd_x      = head.x;
    assign bus.cmd_y      = head.y;
    assign bus.cmd_radius = head.radius;
    assign bus.cmd_type   = head.kind;
    assign bus.error      = error_q;

`ifdef BRUSH_CMD_READBACK_EN
    logic [15:0] rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_q <= '0;
        else if (bus.chipselect && bus.read_enable) begin
            case (act)
                ACT_X:      rd_q <= 16'(stg.x);
                ACT_Y:      rd_q <= 16'(stg.y);
                ACT_RADIUS: rd_q <= 16'(stg.radius);
                ACT_TYPE:   rd_q <= 16'(stg.kind);
                ACT_COMMIT: rd_q <= 16'({error_q, bus.count});
                default:    rd_q <= '0;
            endcase
        end
    end

    assign bus.readdata = rd_q;
`endif

endmodule
